// File: rtl/pc_incr_seq.sv
// pc_incr_seq: byte-serial program counter incrementer.
// A single 8-bit incrementer walks the PC from byte 0 upward and stops at the
// first byte that does not carry out, so an increment takes 1-4 INC cycles.
// Direct loads (branch/jump targets) complete in one cycle and may be issued
// back-to-back while idle.
module pc_incr_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [31:0] req_value,
  output logic [31:0] pc,
  output logic        done,
  output logic        ovf,
  output logic [1:0]  byte_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    INC  = 1'b1
  } state_t;

  state_t state;

  // Shared byte incrementer: returns {carry_out, byte + 1}.
  function automatic logic [8:0] incr_byte(input logic [7:0] b);
    return {1'b0, b} + 9'd1;
  endfunction

  logic [7:0] cur_byte;
  logic [8:0] byte_sum;

  // Select the byte under work and feed it through the one shared adder.
  always_comb begin
    cur_byte = pc[8*byte_idx +: 8];
    byte_sum = incr_byte(cur_byte);
  end

  // Sequencer: handshake in IDLE, one byte per cycle in INC, registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_ready <= 1'b1;
      done      <= 1'b0;
      ovf       <= 1'b0;
      byte_idx  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          ovf  <= 1'b0;
          if (req_valid) begin
            if (req_load) begin
              pc   <= req_value;
              done <= 1'b1;
            end else begin
              state     <= INC;
              req_ready <= 1'b0;
              byte_idx  <= 2'd0;
            end
          end
        end
        INC: begin
          // Bytes above the terminating one are never touched.
          pc[8*byte_idx +: 8] <= byte_sum[7:0];
          if (byte_sum[8] && (byte_idx != 2'd3)) begin
            byte_idx <= byte_idx + 2'd1;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
            byte_idx  <= 2'd0;
            done      <= 1'b1;
            // A carry out of byte 3 means the whole PC wrapped to zero.
            ovf       <= byte_sum[8];
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          byte_idx  <= 2'd0;
          done      <= 1'b0;
          ovf       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_incr_seq.sv
// Scoreboard bench for pc_incr_seq: the driver pushes the expected result of
// every accepted request, the monitor pops on each done pulse and also tracks
// req_ready / byte_idx against the expected busy window.
module tb_pc_incr_seq;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [31:0] req_value;
  logic [31:0] pc;
  logic        done;
  logic        ovf;
  logic [1:0]  byte_idx;

  pc_incr_seq #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_load  (req_load),
    .req_value (req_value),
    .pc        (pc),
    .done      (done),
    .ovf       (ovf),
    .byte_idx  (byte_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_pc;
  int          busy_start = 0;
  int          ready_at   = 0;
  int          n_chk      = 0;
  int          n_fail     = 0;
  int          n_issued   = 0;
  int          n_done     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: number of INC cycles is 1 + run of 0xFF bytes from byte 0, max 4.
  function automatic int calc_k(input logic [31:0] v);
    int k = 1;
    for (int i = 0; i < 3; i++) begin
      if (v[8*i +: 8] == 8'hFF) k++;
      else break;
    end
    return k;
  endfunction

  // Issue one request; returns just after the accept edge.
  task automatic do_req(input logic ld, input logic [31:0] val);
    int   g = 0;
    exp_t e;
    int   k;
    @(negedge clk);
    req_valid = 1'b1;
    req_load  = ld;
    req_value = val;
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      return;
    end
    @(posedge clk);
    #1;
    n_issued++;
    if (ld) begin
      model_pc   = val;
      e.pc       = val;
      e.ovf      = 1'b0;
      e.done_cyc = cyc;
      ready_at   = cyc;
    end else begin
      k          = calc_k(model_pc);
      e.ovf      = (model_pc == 32'hFFFF_FFFF);
      model_pc   = model_pc + 32'd1;
      e.pc       = model_pc;
      e.done_cyc = cyc + k;
      busy_start = cyc;
      ready_at   = cyc + k;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: handshake/debug visibility every cycle, results on done.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (cyc < ready_at) begin
        chk("ready_busy", 32'(req_ready), 32'd0);
        chk("byte_idx_seq", 32'(byte_idx), 32'(cyc - busy_start));
      end else begin
        chk("ready_idle", 32'(req_ready), 32'd1);
        chk("byte_idx_idle", 32'(byte_idx), 32'd0);
      end
      if (done) begin
        n_done++;
        if (q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("pc_result", pc, e.pc);
          chk("ovf", 32'(ovf), 32'(e.ovf));
          chk("latency", 32'(cyc), 32'(e.done_cyc));
        end
      end
    end
  end

  initial begin
    int g;
    int dcnt;
    logic [31:0] v;
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_value = 32'h0;
    model_pc  = RESET_PC;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_byte_idx", 32'(byte_idx), 32'd0);
    #2 rst = 1'b1;

    // Increment straight out of reset.
    do_req(1'b0, 32'h0);
    idle(3);

    // Carry chains of length 2 and 3, then the full wrap.
    do_req(1'b1, 32'h1234_56FF);
    do_req(1'b0, 32'h0);
    idle(2);
    do_req(1'b1, 32'h12FF_FFFF);
    do_req(1'b0, 32'h0);
    idle(2);
    do_req(1'b1, 32'hFFFF_FFFF);
    do_req(1'b0, 32'h0);
    idle(2);

    // Back-to-back increments with req_valid held high.
    do_req(1'b1, 32'h0000_00FE);
    dcnt = n_done;
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'h0);
    idle(6);
    chk("b2b_done_count", 32'(n_done - dcnt), 32'd5);

    // Loads on consecutive cycles.
    do_req(1'b1, 32'h0000_000A);
    do_req(1'b1, 32'h0000_000B);
    do_req(1'b1, 32'h0000_000C);
    idle(2);

    // Reset during the second INC cycle of a 3-byte carry chain.
    do_req(1'b1, 32'h00FF_FFFF);
    do_req(1'b0, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_pc", pc, RESET_PC);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    n_issued -= q.size();
    q.delete();
    model_pc = RESET_PC;
    ready_at = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    do_req(1'b0, 32'h0);
    idle(3);

    // Randomised mix of loads (biased toward 0xFF low bytes) and increments.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = $urandom;
        for (int i = 0; i < int'($urandom_range(0, 4)); i++) begin
          if (i < 4) v[8*i +: 8] = 8'hFF;
        end
        do_req(1'b1, v);
      end else begin
        do_req(1'b0, 32'h0);
      end
      if ($urandom_range(0, 5) == 0) idle($urandom_range(0, 3));
    end

    idle(1);
    g = 0;
    while (q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    chk("done_total", 32'(n_done), 32'(n_issued));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
